alu_operand_loader: RTL and testbench
=====================================

# alu_operand_loader

Board-input front end that sits directly upstream of the 4-bit ALU. Using four slide switches and a debounced "next" push-button, it loads operand A, operand B and the 3-bit opcode in sequence. It holds all three stable on the ALU inputs and flags when a complete operand set is present. A debounced "clear" button and the synchronous reset return it to the empty state.

## Interface
- `DEBOUNCE_CYCLES`, default 250000: consecutive stable cycles required before a button level change is accepted; minimum 1; counter width is `$clog2(DEBOUNCE_CYCLES+1)`.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `sw`  in  4  raw, asynchronous slide switches.
- `btn_next`  in  1  raw, asynchronous, bouncy "next" button; active-high.
- `btn_clear`  in  1  raw, asynchronous, bouncy "clear" button; active-high.
- `a_out`  out  4  operand A to the ALU `A` input.
- `b_out`  out  4  operand B to the ALU `B` input.
- `sel_out`  out  3  opcode to the ALU `sel` input.
- `operands_valid`  out  1  high while A, B and sel are all loaded.
- `state_led`  out  2  current FSM state encoding, for board LEDs.

## Operation
- **Input synchronisation**
  - `sw`, `btn_next` and `btn_clear` each pass through a 2-flop synchroniser.
  - All downstream logic uses only the synchronised values.
- **Debounce (per button)**
  - Keep a debounced level `db` (reset 0) and a counter (reset 0).
  - When sync ≠ `db`, the counter increments.
  - When sync = `db`, the counter clears to 0.
  - When the counter is at `DEBOUNCE_CYCLES`-1 and sync still ≠ `db`, `db` toggles and the counter clears.
  - Any glitch shorter than `DEBOUNCE_CYCLES` cycles is ignored.
- **Edge detect**
  - `next_pulse` = `db_next` & ~(`db_next` delayed 1 cycle).
  - `clear_pulse` is formed the same way from `db_clear`.
  - Each pulse lasts exactly 1 cycle per accepted press. Holding a button produces no repeats.
  - Release produces no pulse.
- **FSM** (`state_led` encoding in brackets):
  - `S_A` [00] on `next_pulse`: `a_out` ← `sw_sync`; go to `S_B`.
  - `S_B` [01] on `next_pulse`: `b_out` ← `sw_sync`; go to `S_OP`.
  - `S_OP` [10] on `next_pulse`: `sel_out` ← `sw_sync[2:0]` (`sw_sync[3]` is ignored); `operands_valid` ← 1; go to `S_RUN`.
  - `S_RUN` [11] on `next_pulse`: `operands_valid` ← 0; go to `S_A`. `a_out`, `b_out` and `sel_out` keep their old values until each one is reloaded.
  - With no pulse, the state and all outputs hold.
- **Clear**
  - On `clear_pulse`: `a_out`, `b_out` and `sel_out` ← 0; `operands_valid` ← 0; state ← `S_A`.
  - Debounce state is not affected.
- **Priority**: `rst` > `clear_pulse` > `next_pulse`. A simultaneous clear and next executes clear only; the next press is lost.
- `operands_valid` = 1 exactly when the state is `S_RUN`.

## Timing
- **Reset values** (`rst` high at a clock edge):
  - `a_out` = 0, `b_out` = 0, `sel_out` = 0, `operands_valid` = 0, `state_led` = 00.
  - Synchronisers, `db` levels, delay flops and counters all = 0.
  - Reset takes effect mid-debounce or mid-sequence with no residue.
- A button held through reset release is accepted as a new press `DEBOUNCE_CYCLES`+2 edges after release.
- **Press latency**
  - Let edge 0 be the first edge at which the raw button is sampled high and it then stays high.
  - `db` rises after edge `DEBOUNCE_CYCLES`+1.
  - The pulse is high during the following cycle.
  - The FSM and outputs update at edge `DEBOUNCE_CYCLES`+2.
- **Release latency**: the same `DEBOUNCE_CYCLES`+2 edges before a new press can be recognised.
- **Switch capture**: `sw` must be stable for at least 2 edges before the pulse cycle. The value captured is `sw_sync` during the pulse cycle.
- Outputs are fully registered; the ALU sees them change only on clock edges.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
- **Reset**: drive `rst` for 2 cycles with `sw`=1111 and both buttons low → all outputs 0, `state_led`=00; outputs stay 0 for 20 idle cycles.
- **Full load**: `sw`=0101 + press, `sw`=0011 + press, `sw`=1110 + press (each press held 10 cycles, gaps of 10 cycles) → `a_out`=0101, `b_out`=0011, `sel_out`=110, `operands_valid`=1, `state_led`=11. The first update lands exactly 6 edges after the first press sample.
- **Bounce rejection**: toggle `btn_next` high/low every 2 cycles for 20 cycles, then hold low → no state change. Then hold high for 10 cycles → exactly one advance.
- **Wrap from `S_RUN`**: a 4th press → `operands_valid`=0, `state_led`=00, A, B and sel unchanged. A 5th press with `sw`=1001 → `a_out`=1001, `state_led`=01.
- **Clear mid-sequence**: load A=0111, then press clear → all outputs 0, `state_led`=00. Pressing clear and next within the same pulse cycle → clear only.
- **Reset mid-debounce**: assert `rst` 2 cycles into a press while holding the button → outputs 0. Then exactly one advance occurs 6 edges after `rst` deasserts.

Source files
------------

// File: rtl/alu_operand_loader.sv
// Switch/button front end for the 4-bit ALU: debounces "next"/"clear" and
// sequentially latches operand A, operand B and the opcode from the slide switches.
module alu_operand_loader #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw,
    input  logic       btn_next,
    input  logic       btn_clear,
    output logic [3:0] a_out,
    output logic [3:0] b_out,
    output logic [2:0] sel_out,
    output logic       operands_valid,
    output logic [1:0] state_led
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_A   = 2'b00,
        S_B   = 2'b01,
        S_OP  = 2'b10,
        S_RUN = 2'b11
    } state_t;

    state_t state, state_nx;

    logic [3:0] sw_meta, sw_sync;
    logic [1:0] btn_raw, btn_meta, btn_sync, btn_level, btn_level_d, btn_pulse;
    logic [CW-1:0] btn_cnt [2];
    logic       next_pulse, clear_pulse;
    logic [3:0] a_nx, b_nx;
    logic [2:0] sel_nx;

    // Bit 0 is the "next" button, bit 1 the "clear" button.
    assign btn_raw     = {btn_clear, btn_next};
    assign btn_pulse   = btn_level & ~btn_level_d;
    assign next_pulse  = btn_pulse[0];
    assign clear_pulse = btn_pulse[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_meta     <= '0;
            sw_sync     <= '0;
            btn_meta    <= '0;
            btn_sync    <= '0;
            btn_level   <= '0;
            btn_level_d <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                btn_cnt[i] <= '0;
            end
        end else begin
            sw_meta     <= sw;
            sw_sync     <= sw_meta;
            btn_meta    <= btn_raw;
            btn_sync    <= btn_meta;
            btn_level_d <= btn_level;
            // A level change is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
            for (int unsigned i = 0; i < 2; i++) begin
                if (btn_sync[i] == btn_level[i]) begin
                    btn_cnt[i] <= '0;
                end else if (btn_cnt[i] == CNT_LAST) begin
                    btn_level[i] <= ~btn_level[i];
                    btn_cnt[i]   <= '0;
                end else begin
                    btn_cnt[i] <= btn_cnt[i] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        state_nx = state;
        a_nx     = a_out;
        b_nx     = b_out;
        sel_nx   = sel_out;
        if (clear_pulse) begin
            state_nx = S_A;
            a_nx     = '0;
            b_nx     = '0;
            sel_nx   = '0;
        end else if (next_pulse) begin
            unique case (state)
                S_A: begin
                    a_nx     = sw_sync;
                    state_nx = S_B;
                end
                S_B: begin
                    b_nx     = sw_sync;
                    state_nx = S_OP;
                end
                S_OP: begin
                    sel_nx   = sw_sync[2:0];
                    state_nx = S_RUN;
                end
                S_RUN: begin
                    state_nx = S_A;
                end
                default: state_nx = S_A;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_A;
            a_out          <= '0;
            b_out          <= '0;
            sel_out        <= '0;
            operands_valid <= 1'b0;
        end else begin
            state          <= state_nx;
            a_out          <= a_nx;
            b_out          <= b_nx;
            sel_out        <= sel_nx;
            operands_valid <= (state_nx == S_RUN);
        end
    end

    assign state_led = state;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Randomized and directed bench for alu_operand_loader, checked every cycle
// against a sample-history reference model of the debounce and load sequence.
module tb_alu_operand_loader;

    localparam int unsigned DB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sw;
    logic       btn_next;
    logic       btn_clear;
    logic [3:0] a_out;
    logic [3:0] b_out;
    logic [2:0] sel_out;
    logic       operands_valid;
    logic [1:0] state_led;

    always #5 clk = ~clk;

    alu_operand_loader #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk            (clk),
        .rst            (rst),
        .sw             (sw),
        .btn_next       (btn_next),
        .btn_clear      (btn_clear),
        .a_out          (a_out),
        .b_out          (b_out),
        .sel_out        (sel_out),
        .operands_valid (operands_valid),
        .state_led      (state_led)
    );

    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model. A button level is accepted once the last DB synchronised
    // samples all disagree with it; the sample reaching the debouncer before
    // edge n is the raw value taken at edge n-2.
    bit [3:0] m_a, m_b;
    bit [2:0] m_sel;
    int       m_state;
    bit       m_db      [2];
    bit       m_db_prev [2];
    bit       m_hist    [2][DB+1];
    bit [3:0] m_swh     [2];

    always @(posedge clk) begin
        bit raw   [2];
        bit pulse [2];
        bit toggle;
        raw[0] = btn_next;
        raw[1] = btn_clear;
        if (rst) begin
            m_a = 0; m_b = 0; m_sel = 0; m_state = 0;
            m_swh[0] = 0; m_swh[1] = 0;
            for (int b = 0; b < 2; b++) begin
                m_db[b] = 0;
                m_db_prev[b] = 0;
                for (int k = 0; k <= DB; k++) m_hist[b][k] = 0;
            end
        end else begin
            for (int b = 0; b < 2; b++) pulse[b] = m_db[b] & ~m_db_prev[b];
            if (pulse[1]) begin
                m_a = 0; m_b = 0; m_sel = 0; m_state = 0;
            end else if (pulse[0]) begin
                case (m_state)
                    0: m_a = m_swh[1];
                    1: m_b = m_swh[1];
                    2: m_sel = m_swh[1][2:0];
                    default: ;
                endcase
                m_state = (m_state + 1) % 4;
            end
            for (int b = 0; b < 2; b++) begin
                m_db_prev[b] = m_db[b];
                toggle = 1;
                for (int k = 1; k <= DB; k++) if (m_hist[b][k] == m_db[b]) toggle = 0;
                if (toggle) m_db[b] = ~m_db[b];
                for (int k = DB; k >= 1; k--) m_hist[b][k] = m_hist[b][k-1];
                m_hist[b][0] = raw[b];
            end
            m_swh[1] = m_swh[0];
            m_swh[0] = sw;
        end
    end

    bit mon_en = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            check_eq("a_out",          32'(a_out),          32'(m_a));
            check_eq("b_out",          32'(b_out),          32'(m_b));
            check_eq("sel_out",        32'(sel_out),        32'(m_sel));
            check_eq("operands_valid", 32'(operands_valid), 32'(m_state == 3));
            check_eq("state_led",      32'(state_led),      32'(m_state));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_next(input logic [3:0] val);
        sw = val;
        step(3);
        btn_next = 1'b1;
        step(10);
        btn_next = 1'b0;
        step(10);
    endtask

    task automatic press_clear();
        btn_clear = 1'b1;
        step(10);
        btn_clear = 1'b0;
        step(10);
    endtask

    task automatic check_all(input string tag, input logic [3:0] a, input logic [3:0] b,
                             input logic [2:0] s, input logic v, input logic [1:0] st);
        check_eq({tag, "_a"},     32'(a_out),          32'(a));
        check_eq({tag, "_b"},     32'(b_out),          32'(b));
        check_eq({tag, "_sel"},   32'(sel_out),        32'(s));
        check_eq({tag, "_valid"}, 32'(operands_valid), 32'(v));
        check_eq({tag, "_state"}, 32'(state_led),      32'(st));
    endtask

    initial begin
        rst = 1'b1;
        sw = 4'hF;
        btn_next = 1'b0;
        btn_clear = 1'b0;
        step(2);
        mon_en = 1;
        check_all("reset", 4'h0, 4'h0, 3'h0, 1'b0, 2'b00);
        rst = 1'b0;
        step(20);
        check_all("idle", 4'h0, 4'h0, 3'h0, 1'b0, 2'b00);

        // Full load, with exact latency of the first update.
        sw = 4'h5;
        step(3);
        btn_next = 1'b1;
        step(1);
        for (int k = 1; k <= 6; k++) begin
            step(1);
            if (k == 5) check_eq("lat_pre_state", 32'(state_led), 32'h0);
            if (k == 6) begin
                check_eq("lat_state", 32'(state_led), 32'h1);
                check_eq("lat_a",     32'(a_out),     32'h5);
            end
        end
        step(3);
        btn_next = 1'b0;
        step(10);
        press_next(4'h3);
        press_next(4'hE);
        check_all("full", 4'h5, 4'h3, 3'h6, 1'b1, 2'b11);

        // Bounce rejection, then one clean press wraps S_RUN back to S_A.
        for (int i = 0; i < 5; i++) begin
            btn_next = 1'b1;
            step(2);
            btn_next = 1'b0;
            step(2);
        end
        step(10);
        check_all("bounce", 4'h5, 4'h3, 3'h6, 1'b1, 2'b11);
        btn_next = 1'b1;
        step(10);
        btn_next = 1'b0;
        step(10);
        check_all("wrap", 4'h5, 4'h3, 3'h6, 1'b0, 2'b00);
        press_next(4'h9);
        check_all("reload", 4'h9, 4'h3, 3'h6, 1'b0, 2'b01);

        // Clear mid-sequence and clear racing next.
        press_clear();
        press_next(4'h7);
        check_all("load_a7", 4'h7, 4'h0, 3'h0, 1'b0, 2'b01);
        press_clear();
        check_all("clear", 4'h0, 4'h0, 3'h0, 1'b0, 2'b00);
        press_next(4'h7);
        sw = 4'h2;
        step(3);
        btn_next = 1'b1;
        btn_clear = 1'b1;
        step(10);
        btn_next = 1'b0;
        btn_clear = 1'b0;
        step(10);
        check_all("clear_wins", 4'h0, 4'h0, 3'h0, 1'b0, 2'b00);

        // Reset in the middle of a debounce with the button held through it.
        press_next(4'hA);
        btn_next = 1'b1;
        step(2);
        rst = 1'b1;
        step(2);
        check_all("rst_mid", 4'h0, 4'h0, 3'h0, 1'b0, 2'b00);
        rst = 1'b0;
        step(1);
        for (int k = 1; k <= 6; k++) begin
            step(1);
            if (k == 5) check_eq("rst_lat_pre", 32'(state_led), 32'h0);
            if (k == 6) begin
                check_eq("rst_lat_state", 32'(state_led), 32'h1);
                check_eq("rst_lat_a",     32'(a_out),     32'hA);
            end
        end
        btn_next = 1'b0;
        step(12);

        // Randomized traffic; the per-cycle monitor compares against the model.
        for (int it = 0; it < 80; it++) begin
            int act;
            int hold;
            act = int'($urandom_range(0, 11));
            hold = int'($urandom_range(1, 9));
            sw = 4'($urandom);
            step(int'($urandom_range(0, 4)));
            if (act == 0) begin
                rst = 1'b1;
                step(int'($urandom_range(1, 2)));
                rst = 1'b0;
            end else if (act <= 2) begin
                btn_clear = 1'b1;
                step(hold);
                btn_clear = 1'b0;
            end else if (act == 3) begin
                for (int j = 0; j < hold; j++) begin
                    btn_next = 1'($urandom);
                    btn_clear = 1'($urandom_range(0, 3) == 0);
                    sw = 4'($urandom);
                    step(int'($urandom_range(1, 3)));
                end
                btn_next = 1'b0;
                btn_clear = 1'b0;
            end else begin
                btn_next = 1'b1;
                step(hold);
                if (($urandom & 1) != 0) sw = 4'($urandom);
                step(int'($urandom_range(0, 3)));
                btn_next = 1'b0;
            end
            step(int'($urandom_range(1, 12)));
        end

        step(20);
        mon_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
